// File: rtl/axis_ptp_tx_framer.sv
// Builds one 60-byte 802.1AS/PTPv2 Ethernet frame per accepted start and streams it
// on an 8-bit AXI-Stream master; the MAC downstream appends the FCS.
//
// state  | meaning
// S_IDLE | waiting for start; bus idle, tdata forced to 0
// S_SEND | streaming bytes 0..59 of the frame, tvalid held high
module axis_ptp_tx_framer #(
    parameter logic [47:0] SRC_MAC        = 48'h000A35000001,
    parameter logic [63:0] CLOCK_ID       = 64'h000A35FFFE000001,
    parameter logic [15:0] PORT_NUM       = 16'd1,
    parameter logic [7:0]  DOMAIN         = 8'd0,
    parameter logic [3:0]  TRANSPORT_SPEC = 4'd1,
    parameter logic [7:0]  LOG_INTERVAL   = 8'h00
) (
    input  logic        axis_aclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  msg_type,
    input  logic [15:0] seq_id,
    input  logic [79:0] tx_ts,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        done
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      state_q;
    logic [5:0]  idx_q;
    logic [5:0]  idx_d;
    logic [3:0]  msg_type_q;
    logic [15:0] seq_id_q;
    logic [79:0] tx_ts_q;
    logic [7:0]  tdata_q;
    logic        tvalid_q;
    logic        tlast_q;
    logic        busy_q;
    logic        done_q;

    function automatic logic [7:0] ctrl_field(input logic [3:0] mt);
        case (mt)
            4'h0:    return 8'h00;
            4'h1:    return 8'h01;
            4'h8:    return 8'h02;
            4'h9:    return 8'h03;
            default: return 8'h05;
        endcase
    endfunction

    // Whole frame as one big-endian vector; byte i is selected by shifting it to the top.
    function automatic logic [7:0] frame_byte(input logic [5:0]  i,
                                              input logic [3:0]  mt,
                                              input logic [15:0] sq,
                                              input logic [79:0] ts);
        logic [479:0] frame;
        frame = {48'h0180C200000E, SRC_MAC, 16'h88F7,
                 TRANSPORT_SPEC, mt, 8'h02, 16'h002C, DOMAIN, 8'h00,
                 16'h0000, 64'h0, 32'h0,
                 CLOCK_ID, PORT_NUM, sq, ctrl_field(mt), LOG_INTERVAL,
                 ts, 16'h0000};
        frame = frame << {i, 3'b000};
        return frame[479:472];
    endfunction

    assign idx_d = idx_q + 6'd1;

    always_ff @(posedge axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd0;
            msg_type_q <= 4'h0;
            seq_id_q   <= 16'h0;
            tx_ts_q    <= 80'h0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_SEND;
                        idx_q      <= 6'd0;
                        msg_type_q <= msg_type;
                        seq_id_q   <= seq_id;
                        tx_ts_q    <= tx_ts;
                        tdata_q    <= frame_byte(6'd0, msg_type, seq_id, tx_ts);
                        tvalid_q   <= 1'b1;
                        tlast_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (m_axis_tready) begin
                        if (idx_q == 6'd59) begin
                            state_q  <= S_IDLE;
                            idx_q    <= 6'd0;
                            tdata_q  <= 8'h00;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            tdata_q <= frame_byte(idx_d, msg_type_q, seq_id_q, tx_ts_q);
                            tlast_q <= (idx_d == 6'd59);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axis_ptp_tx_framer.sv
// Scoreboard bench for axis_ptp_tx_framer: stimulus pushes expected beats, a negedge
// monitor pops and compares every accepted beat plus stall, tlast and done behaviour.
module tb_axis_ptp_tx_framer;

    localparam logic [47:0] TB_SRC_MAC  = 48'h000A35000001;
    localparam logic [63:0] TB_CLOCK_ID = 64'h000A35FFFE000001;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  msg_type;
    logic [15:0] seq_id;
    logic [79:0] tx_ts;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;

    logic [8:0]  sb[$];
    logic [8:0]  e_mon;
    logic [7:0]  cap [60];
    logic [7:0]  held;
    logic        stall_pend;
    logic        exp_done;
    logic        rand_bp;
    int          frame_beats;
    int          n_vec;
    int          n_err;

    axis_ptp_tx_framer dut (
        .axis_aclk    (clk),
        .rst_n        (rst_n),
        .start        (start),
        .msg_type     (msg_type),
        .seq_id       (seq_id),
        .tx_ts        (tx_ts),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial m_axis_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0] mt, input logic [15:0] sq, input logic [79:0] ts);
        logic [7:0] b [60];
        for (int i = 0; i < 60; i++) b[i] = 8'h00;
        b[0] = 8'h01; b[1] = 8'h80; b[2] = 8'hC2; b[5] = 8'h0E;
        for (int k = 0; k < 6; k++) b[6 + k] = TB_SRC_MAC[47 - 8*k -: 8];
        b[12] = 8'h88; b[13] = 8'hF7;
        b[14] = {4'h1, mt};
        b[15] = 8'h02;
        b[17] = 8'h2C;
        for (int k = 0; k < 8; k++) b[34 + k] = TB_CLOCK_ID[63 - 8*k -: 8];
        b[43] = 8'h01;
        b[44] = sq[15:8]; b[45] = sq[7:0];
        b[46] = (mt == 4'h0) ? 8'h00 : (mt == 4'h1) ? 8'h01 :
                (mt == 4'h8) ? 8'h02 : (mt == 4'h9) ? 8'h03 : 8'h05;
        for (int k = 0; k < 10; k++) b[48 + k] = ts[79 - 8*k -: 8];
        for (int i = 0; i < 60; i++) sb.push_back({1'(i == 59), b[i]});
    endtask

    // Called at posedge+1; start is sampled on the next edge and byte 0 must follow it.
    task automatic send(input logic [3:0] mt, input logic [15:0] sq, input logic [79:0] ts);
        start = 1'b1; msg_type = mt; seq_id = sq; tx_ts = ts;
        push_frame(mt, sq, ts);
        @(posedge clk); #1;
        start = 1'b0;
        chk("latency_tvalid", {15'h0, m_axis_tvalid}, 16'h1);
        chk("latency_byte0", {8'h0, m_axis_tdata}, 16'h01);
    endtask

    task automatic pulse_ignored(input logic [15:0] sq);
        start = 1'b1; seq_id = sq; msg_type = 4'hF; tx_ts = '1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (frame_beats < n && t < 3000) begin @(posedge clk); #1; t++; end
        if (t >= 3000) begin n_vec++; n_err++; $display("FAIL wait_beats timeout: got %0d expected %0d", frame_beats, n); end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy || m_axis_tvalid) && t < 3000) begin @(posedge clk); #1; t++; end
        if (t >= 3000) begin n_vec++; n_err++; $display("FAIL wait_idle timeout: got %0d pending expected 0", sb.size()); end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            frame_beats = 0;
            exp_done    = 1'b0;
            stall_pend  = 1'b0;
        end else begin
            if (exp_done || done) begin
                n_vec++;
                if (done !== exp_done || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_pulse: got done=%b busy=%b expected done=%b busy=0", done, busy, exp_done);
                end
            end
            exp_done = 1'b0;
            if (stall_pend && m_axis_tvalid) begin
                n_vec++;
                if (m_axis_tdata !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h expected %h", m_axis_tdata, held);
                end
            end
            stall_pend = 1'b0;
            if (!m_axis_tvalid && (m_axis_tlast || m_axis_tdata != 8'h00)) begin
                n_vec++; n_err++;
                $display("FAIL idle_bus: got tlast=%b tdata=%h expected 0 0", m_axis_tlast, m_axis_tdata);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got tdata=%h expected no beat", m_axis_tdata);
                end else begin
                    e_mon = sb.pop_front();
                    n_vec++;
                    if ({m_axis_tlast, m_axis_tdata} !== e_mon) begin
                        n_err++;
                        $display("FAIL beat%0d: got tlast=%b tdata=%h expected tlast=%b tdata=%h",
                                 frame_beats, m_axis_tlast, m_axis_tdata, e_mon[8], e_mon[7:0]);
                    end
                    if (frame_beats < 60) cap[frame_beats] = m_axis_tdata;
                    frame_beats++;
                    if (e_mon[8]) begin
                        exp_done    = 1'b1;
                        frame_beats = 0;
                    end
                end
            end else if (m_axis_tvalid) begin
                stall_pend = 1'b1;
                held       = m_axis_tdata;
            end
        end
    end

    initial begin
        logic [7:0] ts_bytes [10];
        int t;
        ts_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'h3B, 8'h9A, 8'hC9, 8'hFF};
        n_vec = 0; n_err = 0; frame_beats = 0;
        exp_done = 1'b0; stall_pend = 1'b0; rand_bp = 1'b0; held = 8'h00;
        rst_n = 1'b0; start = 1'b0; msg_type = 4'h0; seq_id = 16'h0; tx_ts = 80'h0;
        #12;
        chk("rst_tvalid", {15'h0, m_axis_tvalid}, 16'h0);
        chk("rst_tlast", {15'h0, m_axis_tlast}, 16'h0);
        chk("rst_tdata", {8'h0, m_axis_tdata}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_done", {15'h0, done}, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic Sync frame with hand-computed field checks
        send(4'h0, 16'h1234, {48'h000000000064, 32'h3B9AC9FF});
        chk("sync_busy", {15'h0, busy}, 16'h1);
        wait_idle();
        chk("sync_b0", {8'h0, cap[0]}, 16'h01);
        chk("sync_b2", {8'h0, cap[2]}, 16'hC2);
        chk("sync_b12", {cap[12], cap[13]}, 16'h88F7);
        chk("sync_b14", {8'h0, cap[14]}, 16'h10);
        chk("sync_seq", {cap[44], cap[45]}, 16'h1234);
        chk("sync_ctrl", {8'h0, cap[46]}, 16'h00);
        for (int k = 0; k < 10; k++) chk("sync_ts", {8'h0, cap[48 + k]}, {8'h0, ts_bytes[k]});

        // Random backpressure
        rand_bp = 1'b1;
        send(4'h2, 16'h5678, {48'h123456789ABC, 32'h0BADF00D});
        wait_idle();
        rand_bp = 1'b0;
        chk("bp_ctrl", {8'h0, cap[46]}, 16'h05);
        chk("bp_seq", {cap[44], cap[45]}, 16'h5678);

        // Starts during SEND are ignored
        send(4'h1, 16'h0001, {48'h0000000000AA, 32'h00000055});
        wait_beats(10);
        pulse_ignored(16'hBEEF);
        wait_beats(59);
        pulse_ignored(16'hCAFE);
        repeat (20) begin @(posedge clk); #1; end
        chk("ign_busy", {15'h0, busy}, 16'h0);
        chk("ign_seq", {cap[44], cap[45]}, 16'h0001);
        chk("ign_ctrl", {8'h0, cap[46]}, 16'h01);

        // Back-to-back: next start in the done cycle
        send(4'h1, 16'hAAAA, {48'h000000000001, 32'h00000002});
        t = 0;
        while (!done && t < 3000) begin @(posedge clk); #1; t++; end
        chk("b2b_done_seen", {15'h0, done}, 16'h1);
        send(4'h9, 16'hBBBB, {48'h0000000000FF, 32'h12345678});
        wait_idle();
        chk("b2b_seq", {cap[44], cap[45]}, 16'hBBBB);
        chk("b2b_ctrl", {8'h0, cap[46]}, 16'h03);

        // Reset mid-frame, then a full frame
        send(4'h0, 16'h3333, {48'h000000000333, 32'h00000333});
        wait_beats(30);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_tvalid", {15'h0, m_axis_tvalid}, 16'h0);
        chk("mrst_busy", {15'h0, busy}, 16'h0);
        chk("mrst_tlast", {15'h0, m_axis_tlast}, 16'h0);
        chk("mrst_tdata", {8'h0, m_axis_tdata}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_idle", {15'h0, m_axis_tvalid}, 16'h0);
        send(4'h8, 16'h0042, {48'h0000DEADBEEF, 32'h00001000});
        wait_idle();
        chk("fup_ctrl", {8'h0, cap[46]}, 16'h02);
        chk("fup_b14", {8'h0, cap[14]}, 16'h18);
        chk("fup_seq", {cap[44], cap[45]}, 16'h0042);

        send(4'h2, 16'h0043, {48'h000000000007, 32'h00000008});
        wait_idle();
        chk("pdreq_ctrl", {8'h0, cap[46]}, 16'h05);
        chk("pdreq_b14", {8'h0, cap[14]}, 16'h12);
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_ptp_tx_framer.md
# axis_ptp_tx_framer

Generates complete 802.1AS/PTPv2 Ethernet frames on an 8-bit AXI-Stream master for the TX path of the TSN datapath. It is the transmit-side counterpart of the PTP frame classifier. Each accepted `start` produces one 60-byte frame: dst MAC 01:80:C2:00:00:0E, ethertype 0x88F7, a 34-byte PTP header and a 10-byte originTimestamp body, then zero padding. The downstream MAC appends the FCS.

## Interface
- `SRC_MAC`, 48'h000A35000001, source MAC address (bytes 6-11).
- `CLOCK_ID`, 64'h000A35FFFE000001, clockIdentity in sourcePortIdentity.
- `PORT_NUM`, 16'd1, portNumber in sourcePortIdentity.
- `DOMAIN`, 8'd0, domainNumber.
- `TRANSPORT_SPEC`, 4'd1, transportSpecific nibble.
- `LOG_INTERVAL`, 8'h00, logMessageInterval.
- `axis_aclk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `msg_type`  in  4  PTP messageType; captured with `start`.
- `seq_id`  in  16  sequenceId; captured with `start`.
- `tx_ts`  in  80  originTimestamp as {seconds[47:0], nanoseconds[31:0]}; captured with `start`.
- `m_axis_tdata`  out  8  frame byte.
- `m_axis_tvalid`  out  1  byte valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last byte (byte 59).
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last beat.

## Operation
- States: IDLE and SEND.
- IDLE:
  - `start`=1 latches `msg_type`, `seq_id` and `tx_ts`, clears the byte counter `idx` (6 bits) and moves to SEND.
  - `start` while in SEND is ignored. Requests are not queued.
- SEND:
  - `m_axis_tvalid`=1 throughout.
  - `idx` increments on each beat (`tvalid && tready`).
  - On the beat with `idx`=59 the block returns to IDLE and asserts `done` in the next cycle.
- Byte map, indexed by `idx`. Multi-byte fields are big-endian.
  - 0-5: 01 80 C2 00 00 0E
  - 6-11: `SRC_MAC`
  - 12-13: 88 F7
  - 14: {`TRANSPORT_SPEC`, latched msg_type}
  - 15: 0x02 (versionPTP)
  - 16-17: 0x002C (messageLength = 44)
  - 18: `DOMAIN`
  - 19: 0x00
  - 20-21: flags 0x0000
  - 22-29: correctionField 0
  - 30-33: reserved 0
  - 34-41: `CLOCK_ID`
  - 42-43: `PORT_NUM`
  - 44-45: latched seq_id
  - 46: controlField
  - 47: `LOG_INTERVAL`
  - 48-53: ts seconds
  - 54-57: ts nanoseconds
  - 58-59: 0x00
- controlField depends on msg_type:
  - 0x0 → 0x00
  - 0x1 → 0x01
  - 0x8 → 0x02
  - 0x9 → 0x03
  - all others → 0x05
- `m_axis_tlast` = SEND && `idx`==59. It is never asserted outside byte 59.
- `m_axis_tdata` is a registered function of `idx` and the latched fields. It is held stable while `tvalid`=1 and `tready`=0. It is 0x00 when `tvalid`=0.
- Captured fields stay frozen for the whole frame. Changes on the inputs during SEND do not affect the frame in flight.
- Reset, including mid-frame:
  - All outputs go to 0 immediately: `tvalid`, `tlast`, `tdata`, `busy`, `done`.
  - State goes to IDLE and `idx` to 0.
  - A truncated frame is not completed. No `tlast` is produced for it.

## Timing
- Latency: `start` in cycle N puts byte 0 on the bus with `tvalid`=1 in cycle N+1.
- With `tready` held at 1 the frame occupies cycles N+1..N+60 and `tlast` is in N+60.
- `busy`=1 from N+1 through the last-beat cycle. It is 0 in IDLE.
- `done`=1 exactly in the cycle after the last beat; `busy`=0 in that cycle.
- The earliest next accepted `start` is the `done` cycle, which is IDLE. So the minimum spacing is one idle bus cycle between frames.
- Backpressure: any number of `tready`=0 cycles on any byte, including byte 0 and byte 59, only stretches the frame. No byte is skipped or duplicated.
- `tvalid` never deasserts mid-frame except on reset.

## Test plan
- Basic Sync: `tready`=1, `start` with msg_type=0, seq_id=0x1234, tx_ts={48'h000000000064, 32'h3B9AC9FF} → 60 beats exactly.
  - Bytes 0-5 are 01 80 C2 00 00 0E; bytes 12-13 are 88 F7.
  - Byte 14 = 0x10; bytes 44-45 = 12 34; byte 46 = 0x00.
  - Bytes 48-57 = 00 00 00 00 00 64 3B 9A C9 FF.
  - `tlast` only on beat 60; `done` one cycle later.
- Random backpressure: 50% `tready`, msg_type=0x2 → same 60-byte sequence as with no stalls. `tdata` is stable across every stall. Byte 46 = 0x05.
- Ignored start: pulse `start` with different seq_id at beats 10 and 59 of a frame → frame contents unchanged. No second frame follows.
- Back-to-back: `start` asserted in the `done` cycle → second frame begins in the next cycle with its own seq_id.
- Reset mid-frame: deassert `rst_n` at beat 30 → `tvalid`, `busy` and `tlast` are 0 asynchronously. After release, the next `start` yields a full, correct 60-byte frame.
- Follow_Up and Pdelay_Req field check: msg_type=0x8 and then msg_type=0x2 → byte 46 = 0x02 and 0x05 respectively. Byte 14 = 0x18 and 0x12.
